// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
`default_nettype none

package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_buffer.sv
// fetch_buffer: circular FIFO of {pc, instr} entries with flush, push, pop and occupancy.
`default_nettype none

module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned  DEPTH     = 2,
  parameter int unsigned  CNT_W     = $clog2(DEPTH + 1),
  parameter fetch_entry_t RST_ENTRY = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     entry_i,
  input  logic             pop_i,
  output fetch_entry_t     entry_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is allowed then.
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_ENTRY;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  assign entry_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited requests and redirect/kill handling.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect target sets sticky fetch_misaligned and halts.
`default_nettype none

module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        fetch_misaligned,
`endif
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned BUF_CNT_W = $clog2(BUF_DEPTH + 1);
  // One extra bit so outstanding + kill + buffered never overflows.
  localparam int unsigned CNT_W = BUF_CNT_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [31:0] STEP = 32'(INSTR_BYTES);
  localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, instr: 32'h0};

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [31:0]        pc_q;
  logic [31:0]        pc_d;
  logic [31:0]        resp_pc_q;
  logic [31:0]        resp_pc_d;
  logic [CNT_W-1:0]   outstanding_q;
  logic [CNT_W-1:0]   outstanding_d;
  logic [CNT_W-1:0]   kill_cnt_q;
  logic [CNT_W-1:0]   kill_cnt_d;

  logic [BUF_CNT_W-1:0] buf_count;
  logic                 buf_empty;
  logic                 buf_full;
  logic                 buf_flush;
  logic                 buf_push;
  logic                 buf_pop;
  fetch_entry_t         buf_in;
  fetch_entry_t         buf_head;

  logic [CNT_W-1:0]   in_use;
  logic [31:0]        redir_pc;
  logic               redir_bad;
  logic               gnt_fire;
  logic               rsp_drop;
  logic               rsp_accept;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;
  logic misaligned_d;

  assign redir_bad        = redirect && (redirect_pc[1:0] != 2'b00);
  assign redir_pc         = redirect_pc;
  assign misaligned_d     = misaligned_q | redir_bad;
  assign fetch_misaligned = misaligned_q;
`else
  assign redir_bad = 1'b0;
  assign redir_pc  = redirect_pc & ~32'h3;
`endif

  assign in_use = outstanding_q + kill_cnt_q + {1'b0, buf_count};

  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN: begin
        state_d  = RUN;
        imem_req = !redirect && !buf_full && (in_use < DEPTH_C);
      end
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
    if (redir_bad) begin
      state_d = HALT;
    end
  end

  assign gnt_fire   = imem_req && imem_gnt;
  assign rsp_drop   = imem_rvalid && (kill_cnt_q != '0);
  assign rsp_accept = imem_rvalid && !rsp_drop && !redirect;

  always_comb begin
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    kill_cnt_d    = kill_cnt_q;
    if (redirect) begin
      // Everything still owed by memory becomes stale; a response landing now is one fewer.
      pc_d          = redir_pc;
      resp_pc_d     = redir_pc;
      outstanding_d = '0;
      kill_cnt_d    = kill_cnt_q + outstanding_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);
    end else begin
      if (gnt_fire) begin
        pc_d = pc_q + STEP;
      end
      if (rsp_drop) begin
        kill_cnt_d = kill_cnt_q - CNT_W'(1);
      end
      if (rsp_accept) begin
        resp_pc_d = resp_pc_q + STEP;
      end
      outstanding_d = outstanding_q + CNT_W'(gnt_fire) - CNT_W'(rsp_accept);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      kill_cnt_q    <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      kill_cnt_q    <= kill_cnt_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned_q  <= misaligned_d;
`endif
    end
  end

  assign buf_flush = redirect || (state_q == HALT);
  assign buf_push  = rsp_accept;
  assign buf_pop   = if_valid && if_ready;
  assign buf_in    = '{pc: resp_pc_q, instr: imem_rdata};

  fetch_buffer #(
    .DEPTH     (BUF_DEPTH),
    .CNT_W     (BUF_CNT_W),
    .RST_ENTRY (RST_ENTRY)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (buf_flush),
    .push_i  (buf_push),
    .entry_i (buf_in),
    .pop_i   (buf_pop),
    .entry_o (buf_head),
    .count_o (buf_count),
    .empty_o (buf_empty),
    .full_o  (buf_full)
  );

  assign imem_addr = pc_q;
  assign if_valid  = !buf_empty;
  assign if_pc     = buf_head.pc;
  assign if_instr  = buf_head.instr;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that owns the architectural fetch PC, issues in-order requests to instruction memory, buffers returned words, and hands `{pc, instr}` pairs to decode with a valid/ready handshake. It is the consumer of the branch resolution unit's redirect interface (`confirm`, `PcOut`). On a redirect it reloads the PC, flushes buffered words and discards stale in-flight responses.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `BUF_DEPTH`, 2, fetch buffer entries; also the maximum of outstanding requests plus buffered words. Legal values are 2 or 4.

Ports:
- `clk` in 1: single clock. Reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `redirect` in 1: branch/jump taken; driven by the branch unit's `confirm`.
- `redirect_pc` in 32: new fetch address; driven by the branch unit's `PcOut`.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out 32: fetch address; held stable while `imem_req && !imem_gnt`.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid. Responses arrive in order, at least 1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: decode output valid.
- `if_ready` in 1: decode accepts.
- `if_pc` out 32: PC of `if_instr`.
- `if_instr` out 32: instruction word.
- `fetch_misaligned` out 1: present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- **State machine:**
  - BOOT: one cycle after reset release, no request; goes to RUN.
  - RUN: normal fetching.
  - HALT: reachable only with the macro; exits only by reset.
- **Registers:**
  - `pc_q`: next request address.
  - `resp_pc_q`: PC of the next accepted response.
  - `outstanding`: granted requests awaiting a response.
  - `kill_cnt`: stale responses still to be dropped.
  - Buffer: circular FIFO of `{pc, instr}`, BUF_DEPTH entries.
- **Request rule:**
  - `imem_req = RUN && !redirect && (outstanding + kill_cnt + buf_count) < BUF_DEPTH`.
  - On `imem_req && imem_gnt`: `pc_q += 4` (mod 2^32, so 0xFFFF_FFFC wraps to 0) and `outstanding++`.
- **Response rule:**
  - `imem_rvalid` with `kill_cnt != 0`: `kill_cnt--`, data dropped.
  - Otherwise push `{resp_pc_q, imem_rdata}`, `resp_pc_q += 4`, `outstanding--`.
- **Pop:** on `if_valid && if_ready`. Push and pop in the same cycle are both legal.
- **Redirect** (highest priority), in the same cycle:
  - `pc_q <= redirect_pc`, `resp_pc_q <= redirect_pc`.
  - Buffer cleared.
  - `kill_cnt <= kill_cnt + outstanding + (gnt_this_cycle ? 1 : 0) - (rvalid_this_cycle ? 1 : 0)`.
  - `outstanding <= 0`.
  - Any response arriving in the redirect cycle is dropped.
- A redirect in BOOT loads `pc_q`; the FSM still goes to RUN next cycle.
- Back-to-back redirects: the later one wins; `kill_cnt` accumulates.

## Timing
- Reset values:
  - `imem_req` = 0, `imem_addr` = RESET_PC.
  - `if_valid` = 0, `if_pc` = RESET_PC, `if_instr` = 0.
  - `fetch_misaligned` = 0, all counters 0, state BOOT.
- After reset deassertion:
  - First `imem_req` is asserted in the 2nd rising-edge cycle (after BOOT).
  - `imem_addr` is `pc_q`, registered.
- Response to decode: `if_valid` rises the cycle after the accepted `imem_rvalid`. Buffer outputs are registered; there is no same-cycle bypass.
- Redirect:
  - `imem_req` is low combinationally in the redirect cycle.
  - Next cycle `imem_addr = redirect_pc` and `if_valid = 0`.
  - The earliest valid redirected instruction reaches decode 3 cycles after the redirect when memory latency is 1.
- Full buffer: requests stop; no data is lost, because requests are credit-limited.
- Reset mid-operation clears everything asynchronously. Responses arriving after reset are ignored: with `outstanding = 0` and `kill_cnt = 0` they are not expected. The memory side is also reset.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_misaligned` (sticky) and enters HALT.
  - In HALT, `imem_req` = 0 and the buffer is flushed.
- Undefined:
  - The `fetch_misaligned` port is absent.
  - `redirect_pc[1:0]` is forced to 0 and fetch continues.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_e` (BOOT/RUN/HALT).
  - `fetch_entry_t` (`pc`, `instr`).
  - `INSTR_BYTES` = 4.
- One sub-module: `fetch_buffer`, a parameterized circular FIFO of `fetch_entry_t` with flush, push, pop, count, empty and full.

## Test plan
- **Reset and first fetch:** release `rst`, grant every request, latency 1 → `imem_addr` sequence 0x0, 0x4, 0x8; `if_pc`/`if_instr` match in order.
- **Decode stall:** `if_ready` = 0 for 10 cycles → at most BUF_DEPTH grants, `imem_req` drops, no word lost; release → contiguous PCs.
- **Redirect with 2 responses in flight:** redirect to 0x100 → both stale responses dropped; next `if_pc` = 0x100.
- **Redirect coinciding with `imem_rvalid` and `imem_gnt`:** `kill_cnt` is correct; no stale word reaches decode.
- **Wrap-around:** `RESET_PC` = 0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
- **Misaligned redirect to 0x102:**
  - With the macro: `fetch_misaligned` = 1 and `imem_req` stays 0.
  - Without the macro: fetch proceeds from 0x100.
